alu_op_sequencer: RTL
=====================

// Module: alu_op_sequencer
// PURPOSE
//  Command-side master for the 8-bit combinational ALU. Accepts instruction words over a
//  valid/ready port, reads operands from a small internal register file and drives the ALU
//  a/b/opcode inputs. It captures the ALU result and zero flag, writes the result back, and
//  returns a response over a second valid/ready port. Sits between the host/test driver and the ALU.
// PARAMETERS
//  DATA_W  8  datapath width; must match the ALU operand width
//  REG_AW  2  register-file address width (2**REG_AW registers, default 4)
//  INSTR_W derived, not overridable: 4+3*REG_AW+DATA_W (default 18)
// PORTS
//  clk          in   1        single clock, rising edge
//  rst_n        in   1        asynchronous active-low reset
//  instr_valid  in   1        instruction offered
//  instr_ready  out  1        sequencer can accept; transfer when valid&&ready
//  instr_data   in   INSTR_W  {is_load, opcode[2:0], rd, ra, rb, imm[DATA_W-1:0]}, MSB first
//  alu_a        out  DATA_W   ALU operand a (registered)
//  alu_b        out  DATA_W   ALU operand b (registered)
//  alu_op       out  3        ALU opcode (000 add .. 111 set-less-than)
//  alu_result   in   DATA_W   ALU result (combinational from alu_a/alu_b/alu_op)
//  alu_zero     in   1        ALU zero flag
//  resp_valid   out  1        response available
//  resp_ready   in   1        consumer accepts; transfer when valid&&ready
//  resp_data    out  DATA_W   value written to rd
//  resp_zero    out  1        zero flag of resp_data
//  resp_rd      out  REG_AW   destination register of this response
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all regfile entries=0; alu_a/alu_b/resp_data=0; alu_op=000;
//    resp_valid=0; resp_zero=0; resp_rd=0. Reset mid-operation aborts the instruction, with no writeback.
//  instr_ready=1 only in IDLE (registered-state decode). No pipelining: one instruction in flight.
//  FSM states IDLE, ISSUE, CAPTURE, RESP:
//   IDLE: on instr_valid&&instr_ready:
//     is_load=1 -> reg[rd]<=imm; resp_data<=imm; resp_zero<=(imm==0); resp_rd<=rd; ->RESP.
//     is_load=0 -> alu_a<=reg[ra]; alu_b<=reg[rb]; alu_op<=opcode; latch rd; ->ISSUE.
//   ISSUE: one settle cycle, ALU inputs stable; ->CAPTURE.
//   CAPTURE: reg[rd]<=alu_result; resp_data<=alu_result; resp_zero<=alu_zero; resp_rd<=rd; ->RESP.
//   RESP: resp_valid=1; resp_data/zero/rd held stable until resp_ready=1; then ->IDLE.
//  Latency, accept edge to resp_valid: load = 1 cycle; ALU op = 3 cycles. Zero-backpressure
//    throughput: load every 2 cycles; ALU op every 4 cycles.
//  Operands are read in the accept cycle. ra==rd or rb==rd is legal: old value used, new value written.
//  alu_a/alu_b/alu_op hold their last value outside ISSUE/CAPTURE. They change only on ALU-op accept.
//  Arithmetic is done by the ALU: wrap-around modulo 2**DATA_W. The sequencer never modifies results.
//  instr_data is ignored unless valid&&ready. resp_ready is ignored outside RESP.
// CONFIGURATION
//  ALU_SEQ_PERF_EN defined: adds outputs perf_ops[15:0] (responses completed) and perf_zero[15:0]
//    (responses with resp_zero=1). Both increment on the resp handshake cycle, saturate at 16'hFFFF,
//    and reset to 0.
//  ALU_SEQ_PERF_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  Load r1=8'h05, r2=8'h03 -> each resp 1 cycle after accept; resp_data 05/03, resp_zero=0.
//  ADD r0=r1+r2 (op 000) -> alu_a=05, alu_b=03, alu_op=000 in ISSUE; resp 3 cycles later;
//    resp_data=08, resp_rd=0.
//  Load r1=FF, r2=01; ADD r3=r1+r2 -> resp_data=00, resp_zero=1 (wrap).
//  SUB r1=r1-r1 with r1=05 -> resp_data=00, resp_zero=1; r1 reads 00 afterwards.
//  Hold resp_ready=0 for 5 cycles -> resp_valid and resp_* stable, instr_ready=0; accept on 6th.
//  Assert rst_n=0 during ISSUE of ADD r0 -> all outputs at reset values, r0=00 (no writeback).
//  PERF_EN: 3 responses, 1 of them zero -> perf_ops=3, perf_zero=1.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Command-side sequencer for the 8-bit combinational ALU: accepts instructions, reads
// operands from a small register file, drives the ALU and returns responses.
// Optional perf counters are enabled with `define ALU_SEQ_PERF_EN.
module alu_op_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned REG_AW = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            instr_valid,
    output logic                            instr_ready,
    input  logic [4+3*REG_AW+DATA_W-1:0]    instr_data,
    output logic [DATA_W-1:0]               alu_a,
    output logic [DATA_W-1:0]               alu_b,
    output logic [2:0]                      alu_op,
    input  logic [DATA_W-1:0]               alu_result,
    input  logic                            alu_zero,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [DATA_W-1:0]               resp_data,
    output logic                            resp_zero,
    output logic [REG_AW-1:0]               resp_rd
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]                     perf_ops,
    output logic [15:0]                     perf_zero
`endif
);

    localparam int unsigned INSTR_W = 4 + 3*REG_AW + DATA_W;
    localparam int unsigned NREGS   = 2**REG_AW;
    localparam int unsigned RB_LSB  = DATA_W;
    localparam int unsigned RA_LSB  = DATA_W + REG_AW;
    localparam int unsigned RD_LSB  = DATA_W + 2*REG_AW;
    localparam int unsigned OP_LSB  = DATA_W + 3*REG_AW;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   regs_q [NREGS];
    logic [DATA_W-1:0]   regs_d [NREGS];
    logic [DATA_W-1:0]   alu_a_q, alu_a_d;
    logic [DATA_W-1:0]   alu_b_q, alu_b_d;
    logic [2:0]          alu_op_q, alu_op_d;
    logic [REG_AW-1:0]   rd_q, rd_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_zero_q, resp_zero_d;
    logic [REG_AW-1:0]   resp_rd_q, resp_rd_d;

    // Instruction field decode
    logic                f_is_load;
    logic [2:0]          f_op;
    logic [REG_AW-1:0]   f_rd, f_ra, f_rb;
    logic [DATA_W-1:0]   f_imm;

    assign f_is_load = instr_data[INSTR_W-1];
    assign f_op      = instr_data[OP_LSB +: 3];
    assign f_rd      = instr_data[RD_LSB +: REG_AW];
    assign f_ra      = instr_data[RA_LSB +: REG_AW];
    assign f_rb      = instr_data[RB_LSB +: REG_AW];
    assign f_imm     = instr_data[DATA_W-1:0];

    assign instr_ready = (state_q == IDLE);
    assign resp_valid  = (state_q == RESP);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign resp_data   = resp_data_q;
    assign resp_zero   = resp_zero_q;
    assign resp_rd     = resp_rd_q;

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_ops_q, perf_ops_d;
    logic [15:0] perf_zero_q, perf_zero_d;

    assign perf_ops  = perf_ops_q;
    assign perf_zero = perf_zero_q;
`endif

    always_comb begin
        state_d     = state_q;
        regs_d      = regs_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        rd_d        = rd_q;
        resp_data_d = resp_data_q;
        resp_zero_d = resp_zero_q;
        resp_rd_d   = resp_rd_q;
`ifdef ALU_SEQ_PERF_EN
        perf_ops_d  = perf_ops_q;
        perf_zero_d = perf_zero_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    if (f_is_load) begin
                        regs_d[f_rd] = f_imm;
                        resp_data_d  = f_imm;
                        resp_zero_d  = (f_imm == '0);
                        resp_rd_d    = f_rd;
                        state_d      = RESP;
                    end else begin
                        // Operands sampled now, so rd aliasing ra/rb sees the old value
                        alu_a_d  = regs_q[f_ra];
                        alu_b_d  = regs_q[f_rb];
                        alu_op_d = f_op;
                        rd_d     = f_rd;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                regs_d[rd_q] = alu_result;
                resp_data_d  = alu_result;
                resp_zero_d  = alu_zero;
                resp_rd_d    = rd_q;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
`ifdef ALU_SEQ_PERF_EN
                    if (perf_ops_q != 16'hFFFF) begin
                        perf_ops_d = perf_ops_q + 16'd1;
                    end
                    if (resp_zero_q && (perf_zero_q != 16'hFFFF)) begin
                        perf_zero_d = perf_zero_q + 16'd1;
                    end
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= 3'b000;
            rd_q        <= '0;
            resp_data_q <= '0;
            resp_zero_q <= 1'b0;
            resp_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            regs_q      <= regs_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            rd_q        <= rd_d;
            resp_data_q <= resp_data_d;
            resp_zero_q <= resp_zero_d;
            resp_rd_q   <= resp_rd_d;
        end
    end

`ifdef ALU_SEQ_PERF_EN
    // Saturating response counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q  <= 16'd0;
            perf_zero_q <= 16'd0;
        end else begin
            perf_ops_q  <= perf_ops_d;
            perf_zero_q <= perf_zero_d;
        end
    end
`endif

endmodule
